// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file.
// Default geometry, the hard-wired zero register index and a popcount helper.
package regfile_pkg;

    localparam int ZERO_IDX   = 0;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int POP_MAX    = 256;

    // Population count over a zero-extended vector of up to POP_MAX bits.
    function automatic logic [15:0] popcount(input logic [POP_MAX-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int k = 0; k < POP_MAX; k++) begin
            n = n + 16'(v[k]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus bundle between decode/writeback and the register file.
// master: drives rd_addr, wr_*, resv_*; slave: drives rd_data, rd_busy, busy_cnt.
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_READ = 2
);

    logic [N_READ*ADDR_W-1:0] rd_addr;
    logic [N_READ*DATA_W-1:0] rd_data;
    logic [N_READ-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     resv_en;
    logic [ADDR_W-1:0]        resv_addr;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
        output rd_data, rd_busy, busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with registered population count.
// Ports: clk, rst, setEn/setAddr (reserve), clrEn/clrAddr (writeback), busy, busyCnt.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  setEn,
    input  logic [ADDR_W-1:0]     setAddr,
    input  logic                  clrEn,
    input  logic [ADDR_W-1:0]     clrAddr,
    output logic [2**ADDR_W-1:0]  busy,
    output logic [ADDR_W:0]       busyCnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0]   busyNext;
    logic [POP_MAX-1:0] busyWide;
    logic [ADDR_W:0]    cntNext;

    // Clear first so a same-address reservation wins.
    always_comb begin
        busyNext = busy;
        if (clrEn) busyNext[clrAddr] = 1'b0;
        if (setEn) busyNext[setAddr] = 1'b1;
        busyWide = '0;
        busyWide[DEPTH-1:0] = busyNext;
        cntNext = (ADDR_W+1)'(popcount(busyWide));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            busyCnt <= '0;
        end else begin
            busy    <= busyNext;
            busyCnt <= cntNext;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: N_READ combinational reads, one write, busy scoreboard.
// Ports: clk, rst (sync, active high), bus (slave side of regfile_multiport_if).
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic                clk,
    input logic                rst,
    regfile_multiport_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_IDX);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wrEff;
    logic              resvEff;

    // Register 0 swallows writes and reservations when hard-wired.
    // Reset also suppresses the write so nothing is bypassed that cycle.
    assign wrEff = bus.wr_en && !rst &&
                   !(ZERO_REG != 0 && bus.wr_addr == ZERO);
    assign resvEff = bus.resv_en &&
                     !(ZERO_REG != 0 && bus.resv_addr == ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (wrEff) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    regfile_scoreboard #(.ADDR_W(ADDR_W)) uScb (
        .clk     (clk),
        .rst     (rst),
        .setEn   (resvEff),
        .setAddr (bus.resv_addr),
        .clrEn   (wrEff),
        .clrAddr (bus.wr_addr),
        .busy    (busy),
        .busyCnt (bus.busy_cnt)
    );

    for (genvar i = 0; i < N_READ; i++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busyR;

        assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

        // A bypassed write also shows the clear of its busy bit;
        // a same-cycle reservation only lands at the edge.
        always_comb begin
            data  = mem[addr];
            busyR = busy[addr];
            if (BYPASS != 0 && wrEff && bus.wr_addr == addr) begin
                data  = bus.wr_data;
                busyR = 1'b0;
            end
            if (ZERO_REG != 0 && addr == ZERO) begin
                data  = '0;
                busyR = 1'b0;
            end
        end

        assign bus.rd_data[i*DATA_W +: DATA_W] = data;
        assign bus.rd_busy[i] = busyR;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: directed vectors, queued expectations.
// A negedge monitor pops and compares each cycle's expected read results.
module tb_regfile_multiport;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_multiport_if #(.DATA_W(32), .ADDR_W(5), .N_READ(2)) bus ();

    regfile_multiport dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       nm;
        int          port;
        logic [31:0] data;
        logic        busy;
        int          cnt;
    } exp_t;

    exp_t expQ[$];
    int   nTests = 0;
    int   nFail  = 0;

    // Monitor: everything queued for this cycle is checked mid-cycle.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            exp_t e;
            logic [31:0] d;
            logic        b;
            int          c;
            e = expQ.pop_front();
            d = bus.rd_data[e.port*32 +: 32];
            b = bus.rd_busy[e.port];
            c = int'(bus.busy_cnt);
            nTests++;
            if (d !== e.data || b !== e.busy || c != e.cnt) begin
                nFail++;
                $display("FAIL %s port%0d: got data=%0h busy=%b cnt=%0d, want data=%0h busy=%b cnt=%0d",
                         e.nm, e.port, d, b, c, e.data, e.busy, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.resv_en   = 1'b0;
        bus.resv_addr = '0;
    endtask

    task automatic setRd(input int a0, input int a1);
        bus.rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic pushExp(input string nm, input int port,
                           input logic [31:0] d, input logic b,
                           input int c);
        exp_t e;
        e.nm = nm; e.port = port; e.data = d; e.busy = b; e.cnt = c;
        expQ.push_back(e);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = 5'(a); bus.wr_data = d;
    endtask

    task automatic resv(input int a);
        bus.resv_en = 1'b1; bus.resv_addr = 5'(a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        setRd(0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 1: reset contents on both ports
        for (int r = 1; r < 32; r++) begin
            setRd(r, 32 - r);
            pushExp("rst_p0", 0, 32'd0, 1'b0, 0);
            pushExp("rst_p1", 1, 32'd0, 1'b0, 0);
            tick();
        end

        // 2: write r17, bypass then registered read
        wr(17, 32'd17697); setRd(17, 18);
        pushExp("wr17_byp", 0, 32'd17697, 1'b0, 0);
        pushExp("wr17_r18", 1, 32'd0, 1'b0, 0);
        tick(); idle();
        pushExp("rd17", 0, 32'd17697, 1'b0, 0);
        pushExp("rd18", 1, 32'd0, 1'b0, 0);
        tick();

        // 3: register 0 ignores writes and reservations
        wr(0, 32'hFFFF_FFFF); resv(0); setRd(0, 0);
        pushExp("r0_same", 0, 32'd0, 1'b0, 0);
        pushExp("r0_same", 1, 32'd0, 1'b0, 0);
        tick(); idle();
        pushExp("r0_next", 0, 32'd0, 1'b0, 0);
        tick();

        // 4: reserve r5, then writeback clears it
        resv(5); setRd(5, 5);
        pushExp("resv5_same", 0, 32'd0, 1'b0, 0);
        tick(); idle();
        pushExp("resv5_next", 0, 32'd0, 1'b1, 1);
        pushExp("resv5_next", 1, 32'd0, 1'b1, 1);
        tick();
        wr(5, 32'd42);
        pushExp("wr5_byp_p0", 0, 32'd42, 1'b0, 1);
        pushExp("wr5_byp_p1", 1, 32'd42, 1'b0, 1);
        tick(); idle();
        pushExp("wr5_next", 0, 32'd42, 1'b0, 0);
        tick();

        // 5: reserve and write r9 together while busy
        resv(9); setRd(9, 9);
        pushExp("resv9_same", 0, 32'd0, 1'b0, 0);
        tick(); idle();
        resv(9); wr(9, 32'd7);
        pushExp("rw9_byp", 0, 32'd7, 1'b0, 1);
        tick(); idle();
        pushExp("rw9_next", 0, 32'd7, 1'b1, 1);
        tick();

        // set r10 and clear r9 in one cycle: count unchanged
        resv(10); wr(9, 32'd8); setRd(9, 10);
        pushExp("swap_byp9", 0, 32'd8, 1'b0, 1);
        pushExp("swap_r10", 1, 32'd0, 1'b0, 1);
        tick(); idle();
        pushExp("swap_r9", 0, 32'd8, 1'b0, 1);
        pushExp("swap_r10n", 1, 32'd0, 1'b1, 1);
        tick();

        // re-reserve busy r10 and clear free r11: no count change
        resv(10); wr(11, 32'd3); setRd(10, 11);
        tick(); idle();
        pushExp("rerv_r10", 0, 32'd0, 1'b1, 1);
        pushExp("clrfree11", 1, 32'd3, 1'b0, 1);
        tick();

        // 6: reservations wiped by reset, reset beats write
        resv(3); setRd(3, 4);
        tick(); idle();
        resv(4);
        pushExp("resv3_next", 0, 32'd0, 1'b1, 2);
        tick(); idle();
        pushExp("resv34", 1, 32'd0, 1'b1, 3);
        rst = 1'b1; wr(3, 32'd5);
        tick(); idle();
        rst = 1'b0;
        pushExp("post_rst_r3", 0, 32'd0, 1'b0, 0);
        pushExp("post_rst_r4", 1, 32'd0, 1'b0, 0);
        tick();
        setRd(17, 10);
        pushExp("post_rst_r17", 0, 32'd0, 1'b0, 0);
        pushExp("post_rst_r10", 1, 32'd0, 1'b0, 0);
        tick();

        @(negedge clk);
        #1;
        nTests++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL drain: got %0d pending, want 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
